pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller for the core. It sequences instruction fetch and execute: it issues fetch requests to instruction memory, waits for the core to finish each instruction, and then picks the next PC.
- Next-PC sources: sequential, absolute jump target, or jump-label table entry.
- The block owns the jump-label table, which is reset-initialised and runtime-writable.
- Sits between the decode/execute stage and instruction memory.

Parameters:
- PC_W, 16, width of the PC, jump targets and label entries.
- RESET_PC, 16'd0, PC loaded on reset.
- N_LABELS, 16, number of jump-label table entries (index width is $clog2(N_LABELS) = 4).
- ACK_TIMEOUT, 32, maximum cycles FETCH waits for imem_ack before declaring a fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE, or resume from HALT (not after a fault).
- halt_req  in  1  stop after the current instruction completes.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  PC_W  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  instruction memory has returned the instruction.
- instr_valid  out  1  one-cycle pulse: instruction is available to the core.
- exec_done  in  1  core has finished the current instruction; branch inputs are valid this cycle.
- br_kind  in  2  next-PC source: 00 sequential, 01 absolute, 10 label, 11 return.
- br_taken  in  1  branch condition; if low, next PC is pc+1 whatever br_kind is.
- br_target  in  PC_W  absolute jump target.
- br_label  in  4  jump-label table index.
- lbl_we  in  1  label-table write enable.
- lbl_waddr  in  4  label-table write index.
- lbl_wdata  in  PC_W  label-table write data.
- pc  out  PC_W  current PC.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- fault  out  1  sticky; set on fetch timeout or illegal return.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, pc = RESET_PC.
  - imem_req, instr_valid, busy, halted and fault all 0; timeout counter 0.
  - Label table loaded with LABEL_INIT: entries 0-8 = 9, 19, 76, 101, 118, 124, 8, 37, 16; entries 9-15 = 0.
  - Reset mid-fetch drops imem_req immediately; no handshake is completed.
- States:
  - IDLE: on start, go to FETCH.
  - FETCH:
    - imem_req = 1, imem_addr = pc; the counter increments each cycle.
    - On imem_ack: go to EXEC, pulse instr_valid in the next cycle, clear the counter.
    - If the counter reaches ACK_TIMEOUT without an ack: fault = 1, go to HALT.
    - imem_req deasserts in the cycle after the ack is sampled.
  - EXEC: wait for exec_done. On exec_done, register the next PC and go to FETCH, or to HALT if halt_req is high in the same cycle (pc is still updated).
  - HALT:
    - halted = 1.
    - start resumes into FETCH at the current pc, only if fault = 0.
    - With fault = 1, only reset leaves HALT.
- Next PC (evaluated on exec_done; takes effect the next cycle):
  - br_taken = 0, or br_kind = 00: pc+1, modulo 2^PC_W (16'hFFFF wraps to 0).
  - 01: br_target.
  - 10: label[br_label].
  - 11: pop the return stack (see Optional Feature). With the feature absent, this sets fault and goes to HALT.
- Fetch-to-fetch latency, including the 1-cycle decision: 1 (ack) + 1 (instr_valid) + the core's exec latency + 1.
- Label table:
  - Writes are accepted in any state and take effect at the next clock edge.
  - A read and a write to the same index in the same cycle return the old value.
  - halt_req in IDLE is ignored; start outside IDLE and HALT is ignored.

Optional Feature:
- Macro: PC_SEQ_CALL_STACK_EN.
- Defined:
  - A 4-deep return-address stack is present.
  - br_kind = 01 with br_taken and br_target[PC_W-1] = 1 is a call: the stack pushes pc+1 and the jump goes to {1'b0, br_target[PC_W-2:0]}.
  - br_kind = 11 pops the stack.
  - Push when full: fault, go to HALT. Pop when empty: fault, go to HALT.
- Undefined:
  - No stack is present and br_target is used unmodified.
  - br_kind = 11 always faults.

Decomposition:
- Package pc_seq_pkg contains:
  - enum seq_state_t {IDLE, FETCH, EXEC, HALT};
  - enum br_kind_t {BR_SEQ, BR_ABS, BR_LABEL, BR_RET};
  - localparam LABEL_INIT array;
  - RSTACK_DEPTH = 4.
- One sub-module: pc_label_table, a 16 x PC_W register file with reset init, one write port and one asynchronous read port.

Test Plan:
- Reset, then start, ack after 2 cycles, exec_done with br_kind = 00 -> imem_addr goes 0, then 1; instr_valid is one pulse per fetch.
- pc = 5, br_kind = 10, br_label = 3, br_taken = 1 -> next fetch at 101. Write label[3] = 200 in the same cycle -> this jump uses 101; the next identical jump uses 200.
- br_kind = 01, br_target = 42, br_taken = 0 at pc = 7 -> next pc = 8. Repeat with br_taken = 1 -> pc = 42.
- pc = 16'hFFFF, sequential -> pc = 0.
- No imem_ack for 32 cycles -> fault = 1, halted = 1, imem_req = 0. start is then ignored; rst_n low clears everything.
- halt_req together with exec_done -> HALT with pc updated; start resumes the fetch at that pc.
- Call-stack variant (macro defined): five nested calls -> fault on the 5th. A return with an empty stack -> fault.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    BR_SEQ   = 2'd0,
    BR_ABS   = 2'd1,
    BR_LABEL = 2'd2,
    BR_RET   = 2'd3
  } br_kind_t;

  localparam int unsigned RSTACK_DEPTH = 4;
  localparam int unsigned LABEL_INIT_N = 16;

  // Entry 0 is the rightmost element.
  localparam logic [LABEL_INIT_N-1:0][15:0] LABEL_INIT = {
    16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
    16'd16, 16'd37, 16'd8, 16'd124, 16'd118, 16'd101, 16'd76, 16'd19, 16'd9
  };

  function automatic logic [15:0] label_init(input int unsigned idx);
    if (idx < LABEL_INIT_N) return LABEL_INIT[4'(idx)];
    return 16'd0;
  endfunction

endpackage

// File: rtl/pc_seq_label_table.sv
// Jump-label register file: reset-initialised, one write port, one async read port.
module pc_label_table
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned N_LABELS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic [$clog2(N_LABELS)-1:0] waddr_i,
  input  logic [PC_W-1:0]             wdata_i,
  input  logic [$clog2(N_LABELS)-1:0] raddr_i,
  output logic [PC_W-1:0]             rdata_o
);

  logic [PC_W-1:0] mem_q [N_LABELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_LABELS; i++) mem_q[i] <= PC_W'(label_init(i));
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle read of a written index sees the old value.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, execute wait, next-PC selection.
// Optional return-address stack enabled by defining PC_SEQ_CALL_STACK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     N_LABELS    = 16,
  parameter int unsigned     ACK_TIMEOUT = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        halt_req,
  output logic                        imem_req,
  output logic [PC_W-1:0]             imem_addr,
  input  logic                        imem_ack,
  output logic                        instr_valid,
  input  logic                        exec_done,
  input  logic [1:0]                  br_kind,
  input  logic                        br_taken,
  input  logic [PC_W-1:0]             br_target,
  input  logic [$clog2(N_LABELS)-1:0] br_label,
  input  logic                        lbl_we,
  input  logic [$clog2(N_LABELS)-1:0] lbl_waddr,
  input  logic [PC_W-1:0]             lbl_wdata,
  output logic [PC_W-1:0]             pc,
  output logic                        busy,
  output logic                        halted,
  output logic                        fault
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_EXEC  = EXEC;
  localparam logic [1:0] S_HALT  = HALT;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             iv_q, iv_d;
  logic             imem_req_q, busy_q, halted_q;
  logic [PC_W-1:0]  pc_inc, lbl_rdata;
  logic             bad;

  assign pc_inc = pc_q + PC_W'(1);

  pc_label_table #(.PC_W(PC_W), .N_LABELS(N_LABELS)) u_labels (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (lbl_we),
    .waddr_i (lbl_waddr),
    .wdata_i (lbl_wdata),
    .raddr_i (br_label),
    .rdata_o (lbl_rdata)
  );

`ifdef PC_SEQ_CALL_STACK_EN
  localparam int unsigned SP_W   = $clog2(RSTACK_DEPTH + 1);
  localparam int unsigned SIDX_W = $clog2(RSTACK_DEPTH);

  logic [PC_W-1:0]   rstack_q [RSTACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              push;
  logic [SIDX_W-1:0] top_idx;

  assign top_idx = SIDX_W'(sp_q - SP_W'(1));

  // Return stack: the return address is always the sequential successor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RSTACK_DEPTH; i++) rstack_q[i] <= '0;
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
      if (push) rstack_q[SIDX_W'(sp_q)] <= pc_inc;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    iv_d    = 1'b0;
    bad     = 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
    sp_d    = sp_q;
    push    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_EXEC;
          iv_d    = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          pc_d    = pc_inc;
          state_d = halt_req ? S_HALT : S_FETCH;
          if (br_taken) begin
            unique case (br_kind)
              BR_ABS: begin
`ifdef PC_SEQ_CALL_STACK_EN
                if (br_target[PC_W-1]) begin
                  if (sp_q == SP_W'(RSTACK_DEPTH)) begin
                    bad = 1'b1;
                  end else begin
                    push = 1'b1;
                    sp_d = sp_q + SP_W'(1);
                    pc_d = {1'b0, br_target[PC_W-2:0]};
                  end
                end else begin
                  pc_d = br_target;
                end
`else
                pc_d = br_target;
`endif
              end
              BR_LABEL: pc_d = lbl_rdata;
              BR_RET: begin
`ifdef PC_SEQ_CALL_STACK_EN
                if (sp_q == '0) begin
                  bad = 1'b1;
                end else begin
                  sp_d = sp_q - SP_W'(1);
                  pc_d = rstack_q[top_idx];
                end
`else
                bad = 1'b1;
`endif
              end
              default: ;
            endcase
          end
          // A faulting branch leaves pc where it was.
          if (bad) begin
            pc_d    = pc_q;
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (start && !fault_q) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      iv_q       <= 1'b0;
      imem_req_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      iv_q       <= iv_d;
      imem_req_q <= (state_d == S_FETCH);
      busy_q     <= (state_d == S_FETCH) || (state_d == S_EXEC);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = iv_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_pc_sequencer;

  localparam int ACK_TIMEOUT = 32;
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, halt_req = 1'b0, imem_ack = 1'b0, exec_done = 1'b0;
  logic [1:0]  br_kind = 2'd0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'd0;
  logic [3:0]  br_label = 4'd0;
  logic        lbl_we = 1'b0;
  logic [3:0]  lbl_waddr = 4'd0;
  logic [15:0] lbl_wdata = 16'd0;
  logic        imem_req, instr_valid, busy, halted, fault;
  logic [15:0] imem_addr, pc;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .exec_done(exec_done), .br_kind(br_kind),
    .br_taken(br_taken), .br_target(br_target), .br_label(br_label),
    .lbl_we(lbl_we), .lbl_waddr(lbl_waddr), .lbl_wdata(lbl_wdata),
    .pc(pc), .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;
  int          m_wait;
  logic [15:0] m_pc;
  bit          m_fault, m_iv;
  logic [15:0] m_lbl [16];
  logic [15:0] m_stk [$];

  task automatic model_reset();
    int init [16] = '{9, 19, 76, 101, 118, 124, 8, 37, 16, 0, 0, 0, 0, 0, 0, 0};
    m_mode = M_IDLE; m_wait = 0; m_pc = 16'd0; m_fault = 0; m_iv = 0;
    for (int i = 0; i < 16; i++) m_lbl[i] = 16'(init[i]);
    m_stk.delete();
  endtask

  task automatic model_step();
    bit          iv = 0;
    bit          bad = 0;
    logic [15:0] nxt;
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_FETCH; m_wait = 0; end
      M_FETCH: begin
        if (imem_ack) begin
          m_mode = M_EXEC; iv = 1;
        end else begin
          m_wait++;
          if (m_wait >= ACK_TIMEOUT) begin m_fault = 1; m_mode = M_HALT; end
        end
      end
      M_EXEC: if (exec_done) begin
        nxt = 16'((int'(m_pc) + 1) % 65536);
        if (br_taken) begin
          case (br_kind)
            2'd1: begin
`ifdef PC_SEQ_CALL_STACK_EN
              if (br_target >= 16'h8000) begin
                if (m_stk.size() == 4) bad = 1;
                else begin m_stk.push_back(nxt); nxt = br_target - 16'h8000; end
              end else nxt = br_target;
`else
              nxt = br_target;
`endif
            end
            2'd2: nxt = m_lbl[br_label];
            2'd3: begin
`ifdef PC_SEQ_CALL_STACK_EN
              if (m_stk.size() == 0) bad = 1;
              else nxt = m_stk.pop_back();
`else
              bad = 1;
`endif
            end
            default: ;
          endcase
        end
        if (bad) begin m_fault = 1; m_mode = M_HALT; end
        else begin m_pc = nxt; m_mode = halt_req ? M_HALT : M_FETCH; m_wait = 0; end
      end
      M_HALT: if (start && !m_fault) begin m_mode = M_FETCH; m_wait = 0; end
      default: ;
    endcase
    m_iv = iv;
    if (lbl_we) m_lbl[lbl_waddr] = lbl_wdata;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_req", imem_req, m_mode == M_FETCH);
      if (imem_req) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", instr_valid, m_iv);
      chk("pc", pc, m_pc);
      chk("busy", busy, m_mode == M_FETCH || m_mode == M_EXEC);
      chk("halted", halted, m_mode == M_HALT);
      chk("fault", fault, m_fault);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic do_fetch(input int delay);
    int n = 0;
    while (!imem_req && n < 64) begin tick(); n++; end
    if (!imem_req) chk("fetch_wait", imem_req, 1'b1);
    repeat (delay) tick();
    imem_ack = 1'b1; tick(); imem_ack = 1'b0;
  endtask

  task automatic do_exec(input logic [1:0] kind, input logic taken, input logic [15:0] tgt,
                         input logic [3:0] lbl, input logic hlt);
    exec_done = 1'b1; br_kind = kind; br_taken = taken; br_target = tgt;
    br_label = lbl; halt_req = hlt;
    tick();
    exec_done = 1'b0; br_taken = 1'b0; halt_req = 1'b0; lbl_we = 1'b0;
  endtask

  initial begin
    int k;
    int ack_div;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 16'd0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_flags", {busy, halted, fault, instr_valid}, 4'b0000);
    cmp_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic sequential fetch
    pulse_start();
    chk("first_addr", imem_addr, 16'd0);
    do_fetch(2);
    chk("iv_pulse", instr_valid, 1'b1);
    chk("req_drop", imem_req, 1'b0);
    do_exec(2'd0, 1'b0, 16'd0, 4'd0, 1'b0);
    chk("seq_addr", imem_addr, 16'd1);
    chk("iv_single", instr_valid, 1'b0);

    // Label jump with simultaneous write to the same entry
    do_fetch(0); do_exec(2'd1, 1'b1, 16'd5, 4'd0, 1'b0);
    chk("abs_5", pc, 16'd5);
    do_fetch(1);
    lbl_we = 1'b1; lbl_waddr = 4'd3; lbl_wdata = 16'd200;
    do_exec(2'd2, 1'b1, 16'd0, 4'd3, 1'b0);
    chk("label_old", pc, 16'd101);
    do_fetch(0); do_exec(2'd2, 1'b1, 16'd0, 4'd3, 1'b0);
    chk("label_new", pc, 16'd200);

    // Not-taken vs taken absolute
    do_fetch(0); do_exec(2'd1, 1'b1, 16'd7, 4'd0, 1'b0);
    do_fetch(0); do_exec(2'd1, 1'b0, 16'd42, 4'd0, 1'b0);
    chk("not_taken", pc, 16'd8);
    do_fetch(0); do_exec(2'd1, 1'b1, 16'd42, 4'd0, 1'b0);
    chk("taken", pc, 16'd42);

    // PC wrap via a label loaded with 16'hFFFF
    lbl_we = 1'b1; lbl_waddr = 4'd5; lbl_wdata = 16'hFFFF; tick(); lbl_we = 1'b0;
    do_fetch(0); do_exec(2'd2, 1'b1, 16'd0, 4'd5, 1'b0);
    chk("pc_ffff", pc, 16'hFFFF);
    do_fetch(0); do_exec(2'd0, 1'b1, 16'd0, 4'd0, 1'b0);
    chk("pc_wrap", pc, 16'd0);

    // Halt with exec_done, then resume
    do_fetch(0); do_exec(2'd1, 1'b1, 16'd300, 4'd0, 1'b1);
    chk("halt_pc", pc, 16'd300);
    chk("halt_flag", {halted, busy}, 2'b10);
    tick();
    pulse_start();
    chk("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 16'd300);

    // Return with empty / absent stack faults
    do_fetch(0); do_exec(2'd3, 1'b1, 16'd0, 4'd0, 1'b0);
    chk("ret_fault", {fault, halted}, 2'b11);
    chk("ret_pc", pc, 16'd300);
    pulse_start();
    chk("fault_sticky", {imem_req, halted}, 2'b01);
    do_reset();
    chk("rst_clear", {fault, halted, pc}, 18'd0);

    // Fetch timeout
    pulse_start();
    repeat (ACK_TIMEOUT - 1) tick();
    chk("pre_timeout", {imem_req, fault}, 2'b10);
    tick();
    chk("timeout", {fault, halted, imem_req}, 3'b110);
    pulse_start();
    chk("timeout_sticky", {halted, imem_req}, 2'b10);
    do_reset();
    chk("timeout_rst", {fault, halted, busy}, 3'b000);

`ifdef PC_SEQ_CALL_STACK_EN
    pulse_start();
    for (int c = 1; c <= 5; c++) begin
      do_fetch(0); do_exec(2'd1, 1'b1, 16'h8000 + 16'(c * 10), 4'd0, 1'b0);
      if (c < 5) chk("call_pc", pc, 16'(c * 10));
    end
    chk("call_overflow", {fault, pc}, {1'b1, 16'd40});
    do_reset();
    pulse_start();
    do_fetch(0); do_exec(2'd1, 1'b1, 16'h8032, 4'd0, 1'b0);
    chk("call_once", pc, 16'd50);
    do_fetch(0); do_exec(2'd3, 1'b1, 16'd0, 4'd0, 1'b0);
    chk("return_pc", pc, 16'd1);
    do_reset();
`endif

    // Randomized traffic; the compare process checks every cycle
    pulse_start();
    for (int c = 0; c < 4000; c++) begin
      ack_div = ((c / 500) % 4 == 3) ? 40 : 3;
      start     = ($urandom % 8) == 0;
      halt_req  = ($urandom % 10) == 0;
      imem_ack  = ($urandom % ack_div) == 0;
      exec_done = ($urandom % 3) == 0;
      k = $urandom % 64;
      br_kind   = (k < 20) ? 2'd0 : (k < 40) ? 2'd1 : (k < 63) ? 2'd2 : 2'd3;
      br_taken  = ($urandom % 4) != 0;
      br_target = 16'($urandom);
      br_label  = 4'($urandom);
      lbl_we    = ($urandom % 4) == 0;
      lbl_waddr = 4'($urandom);
      lbl_wdata = 16'($urandom);
      rst_n     = ($urandom % 300) != 0;
      tick();
    end
    rst_n = 1'b1; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0; lbl_we = 1'b0;
    tick(); tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
